id_hazard_scoreboard: RTL and testbench
=======================================

# id_hazard_scoreboard

Parametrised hazard scoreboard for the pipelined RISC-V core. It sits beside the decode stage and consumes the per-instruction decode signals: rd, RegWrite, DatatoReg (load), rs1use, rs2use and store flag. It keeps a shift-register record of the last STAGES in-flight instructions, then produces the ID stall, the bubble insert and the operand-forwarding selects for the instruction in ID. It replaces the fixed two-bit hazard type with real tracking across a configurable pipeline depth, and adds a stall-cycle performance counter.

## Interface
- STAGES, 3: post-decode stages tracked. Entry 0 is EX, entry STAGES-1 is the last stage before register-file write.
- REG_AW, 5: register address width.
- LOAD_READY, 1: lowest entry index from which a load result may be forwarded.
- SEL_W, $clog2(STAGES+1): width of the forwarding selects.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source register addresses.
- id_rs1use, id_rs2use  in  1  the source is read by this instruction.
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  the instruction writes rd.
- id_is_load  in  1  the instruction is a load (DatatoReg).
- id_is_store  in  1  the instruction is a store; rs2 is store data.
- hold  in  1  global freeze (memory wait); the scoreboard does not advance.
- flush  in  1  taken branch or jump resolved in EX; the ID instruction is discarded.
- stall_id  out  1  hold PC and IF/ID, insert a bubble into EX.
- fwd_a_sel, fwd_b_sel  out  SEL_W  0 = register file; k+1 = forward from entry k.
- store_late_fwd  out  1  store rs2 is taken from the load in entry 0 at the MEM stage.
- stall_cnt  out  32  saturating count of cycles with stall_id=1 and hold=0.

## Operation
- Each entry holds {v, rd, wr, ld}.
- Match for source s at entry k: v & wr & rd!=0 & rd==s & s-use.
- The youngest (lowest k) match wins.
- Load-use hazard: the winning match has ld=1 and k<LOAD_READY. This requires stall_id=1 unless the exception below applies.
- Store exception: the match is on rs2 only, id_is_store=1 and k=0.
  - No stall; store_late_fwd=1.
  - fwd_b_sel=1, meaning forward from entry 0 once it reaches MEM.
  - An rs1 load-use match still stalls.
- stall_id = id_valid & !flush & (rs1 hazard | rs2 hazard).
- fwd selects are 0 when id_valid=0 or there is no match.
- Advance, on a clock edge with hold=0:
  - entry[k] <= entry[k-1] for k>=1.
  - entry[0] <= {id_valid & !stall_id & !flush, id_rd, id_regwrite, id_is_load}. A stall or flush loads a bubble (v=0).
- With hold=1, all entries and stall_cnt keep their values.
- flush has priority over a hazard: stall_id=0 and a bubble is inserted.
- hold has priority over flush: nothing changes, and the datapath keeps flush asserted until hold drops.
- stall_cnt increments on every edge where stall_id=1 and hold=0. It saturates at 32'hFFFF_FFFF.
- rd=x0 never matches.

## Timing
- stall_id, fwd_*_sel and store_late_fwd are combinational from the ID inputs and the entry state. They are valid in the same cycle, and the datapath registers them into ID/EX.
- A load-use stall lasts exactly LOAD_READY cycles when there are no other hazards. With the default, this is 1 cycle.
- Entry state updates one edge after acceptance. A producer accepted at edge n is in entry k after edge n+k.
- Reset (rst_n=0, asynchronous):
  - All entries invalid and stall_cnt=0.
  - As a result stall_id=0, fwd selects 0 and store_late_fwd=0.
- Reset asserted mid-operation discards all in-flight records immediately.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- HAZARD_FWD_EN undefined:
  - fwd_a_sel=fwd_b_sel=0 and store_late_fwd=0.
  - Any match at any entry k<STAGES stalls; loads and ALU results are treated the same.
  - Stalls continue until the producer leaves the scoreboard.

## Test plan
- Back-to-back ALU dependence:
  - add x5 accepted, then sub x6,x5,x1 in ID.
  - Required: stall_id=0, fwd_a_sel=1. The cycle after, with an unrelated instruction in between: fwd_a_sel=2.
- Load-use:
  - lw x7 accepted, then add x8,x7,x7 in ID.
  - Required: stall_id=1 for one cycle, then fwd_a_sel=fwd_b_sel=2, stall_cnt=1.
- Load then store data:
  - lw x7, then sw x7,0(x2).
  - Required: stall_id=0, store_late_fwd=1, fwd_b_sel=1.
- Flush versus hazard:
  - A load-use hazard present with flush=1.
  - Required: stall_id=0 and a bubble in entry 0. With hold=1 and flush=1, the entries are unchanged.
- x0 and reset:
  - addi x0 producer then a use of x0: no forward, no stall.
  - Drop rst_n mid-stall: stall_id falls without waiting for a clock and stall_cnt=0.
- HAZARD_FWD_EN undefined, STAGES=3:
  - Dependent add immediately after the producer.
  - Required: stall_id=1 for 3 cycles, selects always 0.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard
//
// Purpose: hazard scoreboard beside the decode stage. It keeps a shift-register
// record {v, rd, wr, ld} of the last STAGES in-flight instructions. Entry 0 is
// EX and entry STAGES-1 is the last stage before register-file write. From
// these records it derives the ID stall/bubble, the operand-forwarding selects
// and a saturating stall-cycle counter.
//
// Build option: macro HAZARD_FWD_EN.
//   defined   : results are forwarded. Only a load younger than LOAD_READY
//               stalls. A store whose data (rs2) comes from a load in EX takes
//               it late, at MEM (store_late_fwd).
//   undefined : there is no forwarding. Any match stalls until the producer
//               leaves the scoreboard, and all selects are 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rs1/id_rs2       source register addresses, with id_rs1use/id_rs2use
//   id_rd, id_regwrite  destination register and its write enable
//   id_is_load          instruction is a load
//   id_is_store         instruction is a store (rs2 is the store data)
//   hold                global freeze; nothing advances
//   flush               discard the ID instruction (a bubble enters EX)
//   stall_id            hold PC and IF/ID, insert a bubble
//   fwd_a_sel/fwd_b_sel 0 = register file, k+1 = forward from entry k
//   store_late_fwd      store data taken from the entry-0 load at MEM
//   stall_cnt           saturating count of non-held stall cycles
// -----------------------------------------------------------------------------
module id_hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1use,
  input  logic              id_rs2use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_is_store,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_id,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              store_late_fwd,
  output logic [31:0]       stall_cnt
);

  typedef struct packed {
    logic             found;
    logic             ld;
    logic [SEL_W-1:0] idx;
  } match_t;

  logic [STAGES-1:0] v_q, v_d, wr_q, wr_d, ld_q, ld_d;
  logic [REG_AW-1:0] rd_q [STAGES];
  logic [REG_AW-1:0] rd_d [STAGES];
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  match_t            m1_s, m2_s;
  logic              rs1_haz_s, rs2_haz_s, store_exc_s, stall_s;
  logic [SEL_W-1:0]  fwd_a_s, fwd_b_s;

  // Youngest matching producer for one source. The scan runs from oldest to
  // youngest, so a younger match overwrites an older one. x0 never matches.
  function automatic match_t find_youngest(input logic [REG_AW-1:0] src,
                                           input logic              src_use);
    match_t m;
    m = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (src_use && v_q[k] && wr_q[k] && (rd_q[k] != '0) && (rd_q[k] == src)) begin
        m.found = 1'b1;
        m.ld    = ld_q[k];
        m.idx   = SEL_W'(k);
      end
    end
    return m;
  endfunction

  // Source-operand match search against the in-flight records.
  always_comb begin
    m1_s = find_youngest(id_rs1, id_rs1use);
    m2_s = find_youngest(id_rs2, id_rs2use);
  end

`ifdef HAZARD_FWD_EN
  // Forwarding build: only a load that is still too young to forward stalls.
  // A store whose data depends on the EX load is the exception: that data is
  // not needed until MEM, so it is forwarded late and no stall is taken.
  always_comb begin
    rs1_haz_s   = m1_s.found & m1_s.ld & (int'(m1_s.idx) < LOAD_READY);
    store_exc_s = m2_s.found & m2_s.ld & (int'(m2_s.idx) < LOAD_READY)
                & id_is_store & (m2_s.idx == '0);
    rs2_haz_s   = m2_s.found & m2_s.ld & (int'(m2_s.idx) < LOAD_READY) & ~store_exc_s;
    fwd_a_s     = (id_valid && m1_s.found) ? (m1_s.idx + SEL_W'(1)) : '0;
    fwd_b_s     = (id_valid && m2_s.found) ? (m2_s.idx + SEL_W'(1)) : '0;
  end
`else
  logic fwd_unused_s;
  // Interlock-only build: any live producer of a source stalls.
  always_comb begin
    rs1_haz_s   = m1_s.found;
    rs2_haz_s   = m2_s.found;
    store_exc_s = 1'b0;
    fwd_a_s     = '0;
    fwd_b_s     = '0;
  end
  // Inputs and parameters that only the forwarding build consumes.
  assign fwd_unused_s = ^{id_is_store, m1_s.ld, m2_s.ld, m1_s.idx, m2_s.idx,
                          (LOAD_READY > 0)};
`endif

  // A flush discards the ID instruction, so it overrides any hazard.
  always_comb begin
    stall_s = id_valid & ~flush & (rs1_haz_s | rs2_haz_s);
  end

  // Next-state computation for the records and the stall counter. While hold
  // is high, everything keeps its value.
  always_comb begin
    v_d         = v_q;
    wr_d        = wr_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int k = 1; k < STAGES; k++) begin
        v_d[k]  = v_q[k-1];
        wr_d[k] = wr_q[k-1];
        ld_d[k] = ld_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      v_d[0]  = id_valid & ~stall_s & ~flush;
      wr_d[0] = id_regwrite;
      ld_d[0] = id_is_load;
      rd_d[0] = id_rd;
      if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Record and counter registers. Reset discards every in-flight record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= 32'd0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_id       = stall_s;
  assign fwd_a_sel      = fwd_a_s;
  assign fwd_b_sel      = fwd_b_s;
  assign store_late_fwd = id_valid & store_exc_s;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_id_hazard_scoreboard
//
// Table-driven bench for id_hazard_scoreboard (STAGES=3, LOAD_READY=1).
// Each record holds the ID-stage inputs for one cycle and the hand-computed
// outputs for that cycle. The table is selected by HAZARD_FWD_EN to match the
// build. A hand-written sequence covers asynchronous reset in the middle of a
// stall.
// -----------------------------------------------------------------------------
module tb_id_hazard_scoreboard;

  localparam int STAGES     = 3;
  localparam int REG_AW     = 5;
  localparam int LOAD_READY = 1;
  localparam int SEL_W      = 2;
`ifdef HAZARD_FWD_EN
  localparam logic [1:0] FWD_B_SEL_A = 2'd1;
`else
  localparam logic [1:0] FWD_B_SEL_A = 2'd0;
`endif

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_rs1use, id_rs2use, id_regwrite, id_is_load, id_is_store;
  logic              hold, flush;
  logic              stall_id, store_late_fwd;
  logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0]       stall_cnt;

  id_hazard_scoreboard #(
    .STAGES     (STAGES),
    .REG_AW     (REG_AW),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1use      (id_rs1use),
    .id_rs2use      (id_rs2use),
    .id_rd          (id_rd),
    .id_regwrite    (id_regwrite),
    .id_is_load     (id_is_load),
    .id_is_store    (id_is_store),
    .hold           (hold),
    .flush          (flush),
    .stall_id       (stall_id),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .store_late_fwd (store_late_fwd),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        st;
    logic        hd;
    logic        fl;
    logic        e_stall;
    logic [1:0]  e_fa;
    logic [1:0]  e_fb;
    logic        e_slf;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[32];
  int   n_vec    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Append one record: inputs, then the expected outputs for that cycle.
  task automatic add(input int v, input int rs1, input int u1, input int rs2, input int u2,
                     input int rd, input int wr, input int ld, input int st,
                     input int hd, input int fl,
                     input int e_stall, input int e_fa, input int e_fb,
                     input int e_slf, input int e_cnt);
    vec_t t;
    t.v       = 1'(v);
    t.rs1     = 5'(rs1);
    t.u1      = 1'(u1);
    t.rs2     = 5'(rs2);
    t.u2      = 1'(u2);
    t.rd      = 5'(rd);
    t.wr      = 1'(wr);
    t.ld      = 1'(ld);
    t.st      = 1'(st);
    t.hd      = 1'(hd);
    t.fl      = 1'(fl);
    t.e_stall = 1'(e_stall);
    t.e_fa    = 2'(e_fa);
    t.e_fb    = 2'(e_fb);
    t.e_slf   = 1'(e_slf);
    t.e_cnt   = 32'(e_cnt);
    vecs[n_vec] = t;
    n_vec++;
  endtask

  task automatic drive(input vec_t t);
    id_valid    = t.v;
    id_rs1      = t.rs1;
    id_rs1use   = t.u1;
    id_rs2      = t.rs2;
    id_rs2use   = t.u2;
    id_rd       = t.rd;
    id_regwrite = t.wr;
    id_is_load  = t.ld;
    id_is_store = t.st;
    hold        = t.hd;
    flush       = t.fl;
  endtask

  task automatic check_outs(input string tag, input logic e_stall, input logic [1:0] e_fa,
                            input logic [1:0] e_fb, input logic e_slf, input logic [31:0] e_cnt);
    check({tag, " stall_id"},       32'(stall_id),       32'(e_stall));
    check({tag, " fwd_a_sel"},      32'(fwd_a_sel),      32'(e_fa));
    check({tag, " fwd_b_sel"},      32'(fwd_b_sel),      32'(e_fb));
    check({tag, " store_late_fwd"}, 32'(store_late_fwd), 32'(e_slf));
    check({tag, " stall_cnt"},      stall_cnt,           e_cnt);
  endtask

  initial begin
    vec_t idle_v;
    vec_t lw10_v;
    vec_t use10_v;

    // Fields: v, rs1,u1, rs2,u2, rd,wr,ld,st, hold,flush | stall, fa, fb, slf, cnt
`ifdef HAZARD_FWD_EN
    add(0, 0,0, 0,0,  0,0,0,0, 0,0,  0,0,0,0,0);  // idle
    add(1, 1,1, 2,1,  5,1,0,0, 0,0,  0,0,0,0,0);  // add x5,x1,x2
    add(1, 5,1, 1,1,  6,1,0,0, 0,0,  0,1,0,0,0);  // sub x6,x5,x1: forward from EX
    add(1, 5,1, 6,1,  5,1,0,0, 0,0,  0,2,1,0,0);  // x5 one stage older, x6 in EX
    add(1, 5,1, 6,1,  0,0,0,0, 0,0,  0,1,2,0,0);  // youngest x5 producer wins
    add(1, 2,1, 0,0,  7,1,1,0, 0,0,  0,0,0,0,0);  // lw x7
    add(1, 7,1, 7,1,  8,1,0,0, 0,0,  1,1,1,0,0);  // add x8,x7,x7: load-use stall
    add(1, 7,1, 7,1,  8,1,0,0, 0,0,  0,2,2,0,1);  // released one cycle later
    add(1, 2,1, 0,0,  7,1,1,0, 0,0,  0,0,0,0,1);  // lw x7
    add(1, 2,1, 7,1,  0,0,0,1, 0,0,  0,0,1,1,1);  // sw x7,0(x2): late store forward
    add(1, 2,1, 0,0,  7,1,1,0, 0,0,  0,0,0,0,1);  // lw x7
    add(1, 7,1, 0,0,  7,1,0,0, 0,1,  0,1,0,0,1);  // hazard under flush: no stall
    add(1, 7,1, 0,0,  0,0,0,0, 0,0,  0,2,0,0,1);  // flushed slot became a bubble
    add(1, 2,1, 0,0,  9,1,1,0, 0,0,  0,0,0,0,1);  // lw x9
    add(1, 9,1, 0,0,  3,1,0,0, 1,1,  0,1,0,0,1);  // hold+flush: nothing moves
    add(1, 9,1, 0,0,  3,1,0,0, 0,0,  1,1,0,0,1);  // lw x9 still in EX
    add(1, 9,1, 0,0,  3,1,0,0, 0,0,  0,2,0,0,2);
    add(1, 0,1, 0,1,  0,1,0,0, 0,0,  0,0,0,0,2);  // addi x0
    add(1, 0,1, 0,1,  4,1,0,0, 0,0,  0,0,0,0,2);  // use of x0: never matches
`else
    add(0, 0,0, 0,0,  0,0,0,0, 0,0,  0,0,0,0,0);  // idle
    add(1, 1,1, 2,1,  5,1,0,0, 0,0,  0,0,0,0,0);  // add x5
    add(1, 5,1, 1,1,  6,1,0,0, 0,0,  1,0,0,0,0);  // dependent: stall 1 of 3
    add(1, 5,1, 1,1,  6,1,0,0, 0,0,  1,0,0,0,1);  // stall 2 of 3
    add(1, 5,1, 1,1,  6,1,0,0, 0,0,  1,0,0,0,2);  // stall 3 of 3
    add(1, 5,1, 1,1,  6,1,0,0, 0,0,  0,0,0,0,3);  // producer gone: accepted
    add(1, 3,1, 6,1, 11,1,0,0, 1,0,  1,0,0,0,3);  // stall under hold: not counted
    add(1, 3,1, 6,1, 11,1,0,0, 0,0,  1,0,0,0,3);
    add(1, 3,1, 6,1, 11,1,0,0, 0,1,  0,0,0,0,4);  // flush beats hazard
    add(1, 6,0,11,1,  0,1,0,0, 0,0,  0,0,0,0,4);  // rs1 unused; x11 was bubbled
    add(1, 0,1, 0,1,  9,1,1,0, 0,0,  0,0,0,0,4);  // uses x0 after addi x0; lw x9
    add(1, 9,1, 4,1, 12,1,0,0, 1,1,  0,0,0,0,4);  // hold+flush: nothing moves
    add(1, 9,1, 4,1, 12,1,0,0, 0,0,  1,0,0,0,4);  // lw x9 still in entry 0
    add(0, 9,1, 4,1, 12,1,0,0, 0,0,  0,0,0,0,5);  // invalid ID never stalls
    add(1, 2,1, 9,1,  9,0,0,1, 0,0,  1,0,0,0,5);  // store on lw x9 in entry 2
    add(1, 2,1, 9,1,  9,0,0,1, 0,0,  0,0,0,0,6);  // lw x9 retired
    add(1, 9,1, 9,1,  0,0,0,0, 0,0,  0,0,0,0,6);  // store rd with wr=0 never matches
`endif

    idle_v = vecs[0];

    // Reset state
    rst_n = 1'b0;
    drive(idle_v);
    id_valid  = 1'b1;
    id_rs1    = 5'd5;
    id_rs1use = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", 1'b0, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_fa,
                 vecs[i].e_fb, vecs[i].e_slf, vecs[i].e_cnt);
    end

    // Asynchronous reset in the middle of a stall
    lw10_v      = idle_v;
    lw10_v.v    = 1'b1;
    lw10_v.rs1  = 5'd2;
    lw10_v.u1   = 1'b1;
    lw10_v.rd   = 5'd10;
    lw10_v.wr   = 1'b1;
    lw10_v.ld   = 1'b1;
    use10_v     = idle_v;
    use10_v.v   = 1'b1;
    use10_v.rs1 = 5'd10;
    use10_v.u1  = 1'b1;

    @(negedge clk);
    drive(lw10_v);
    #1;
    check("lw10 stall_id", 32'(stall_id), 32'd0);
    @(negedge clk);
    drive(use10_v);
    #1;
    check("use10 stall_id", 32'(stall_id), 32'd1);
    check("use10 fwd_a_sel", 32'(fwd_a_sel), 32'(FWD_B_SEL_A));
    check("use10 stall_cnt nonzero", 32'(stall_cnt != 32'd0), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("midreset", 1'b0, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("postreset", 1'b0, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    drive(idle_v);
    #1;
    check("postreset idle stall_cnt", stall_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
